// File: rtl/gb_apu_frame_sequencer.sv
// Game Boy APU frame sequencer: 512 Hz base event -> length / sweep / envelope strobes.
// Optional macro GB_APU_FS_LENGTH_QUIRK_EN adds the length_half output.
module gb_apu_frame_sequencer #(
  parameter int unsigned CLK_DIV    = 8192,
  parameter int unsigned PRESCALE_W = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       apu_enable,
  input  logic       use_ext_div,
  input  logic       div_bit,
  output logic       clk_length_ctr,
  output logic       clk_sweep,
  output logic       clk_vol_env,
`ifdef GB_APU_FS_LENGTH_QUIRK_EN
  output logic       length_half,
`endif
  output logic [2:0] step
);

  localparam logic [PRESCALE_W-1:0] PS_LAST = PRESCALE_W'(CLK_DIV - 1);

  logic [PRESCALE_W-1:0] prescaler;
  logic                  div_prev;
  logic                  ev_int;
  logic                  ev_ext;
  logic                  ev;
  logic [2:0]            step_next;

  always_comb begin
    ev_int    = (prescaler == PS_LAST);
    ev_ext    = div_prev & ~div_bit;
    ev        = use_ext_div ? ev_ext : ev_int;
    step_next = ev ? step + 3'd1 : step;
  end

  // DIV history runs unconditionally so a mode switch sees a valid edge history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_prev <= 1'b0;
    else        div_prev <= div_bit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         prescaler <= '0;
    else if (!apu_enable || use_ext_div) prescaler <= '0;
    else if (ev_int)                    prescaler <= '0;
    else                                prescaler <= prescaler + PRESCALE_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_length_ctr <= 1'b0;
      clk_sweep      <= 1'b0;
      clk_vol_env    <= 1'b0;
      step           <= '0;
    end else if (!apu_enable) begin
      clk_length_ctr <= 1'b0;
      clk_sweep      <= 1'b0;
      clk_vol_env    <= 1'b0;
      step           <= '0;
    end else begin
      // Schedule decoded from the step being executed, not the one that follows.
      clk_length_ctr <= ev & ~step[0];
      clk_sweep      <= ev & (step[1:0] == 2'b10);
      clk_vol_env    <= ev & (step == 3'd7);
      step           <= step_next;
    end
  end

`ifdef GB_APU_FS_LENGTH_QUIRK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           length_half <= 1'b0;
    else if (!apu_enable) length_half <= 1'b0;
    else                  length_half <= step_next[0];
  end
`endif

endmodule

// File: tb/tb_gb_apu_frame_sequencer.sv
// Scoreboard bench for gb_apu_frame_sequencer: event-count reference model feeds a queue, negedge monitor checks.
module tb_gb_apu_frame_sequencer;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       apu_enable = 1'b0;
  logic       use_ext_div = 1'b0;
  logic       div_bit = 1'b0;
  logic       clk_length_ctr, clk_sweep, clk_vol_env;
  logic [2:0] step;
  logic       lh;

  gb_apu_frame_sequencer #(.CLK_DIV(CLK_DIV), .PRESCALE_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .apu_enable(apu_enable),
    .use_ext_div(use_ext_div),
    .div_bit(div_bit),
    .clk_length_ctr(clk_length_ctr),
    .clk_sweep(clk_sweep),
    .clk_vol_env(clk_vol_env),
`ifdef GB_APU_FS_LENGTH_QUIRK_EN
    .length_half(lh),
`endif
    .step(step)
  );
`ifndef GB_APU_FS_LENGTH_QUIRK_EN
  assign lh = 1'b0;
`endif

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit running = 0;
  logic [6:0] q[$];

  // Reference model: number of events since enable, and cycles since the prescaler restarted.
  int n_ev = 0;
  int pre_c = 0;
  bit prev_div = 0;
  int cnt_len = 0, cnt_sw = 0, cnt_env = 0;
  bit did_rst = 0;

  function automatic logic [6:0] pack_out();
    return {lh, clk_length_ctr, clk_sweep, clk_vol_env, step};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic model_cycle(input bit en, input bit ext, input bit db);
    bit ev;
    int s;
    logic len, sw, env, half;
    ev  = ext ? (prev_div && !db) : ((pre_c % CLK_DIV) == CLK_DIV - 1);
    len = 1'b0; sw = 1'b0; env = 1'b0;
    if (!en) begin
      n_ev  = 0;
      pre_c = 0;
    end else begin
      if (ev) begin
        s   = n_ev % 8;
        len = (s % 2 == 0);
        sw  = (s == 2 || s == 6);
        env = (s == 7);
        n_ev++;
      end
      pre_c = ext ? 0 : pre_c + 1;
    end
    prev_div = db;
    s = n_ev % 8;
`ifdef GB_APU_FS_LENGTH_QUIRK_EN
    half = 1'(s % 2);
`else
    half = 1'b0;
`endif
    q.push_back({half, len, sw, env, 3'(s)});
  endtask

  // One clock: sample outputs, optionally fire an asynchronous reset, else drive inputs.
  task automatic tick(input bit en, input bit ext, input bit db, input bit rst_on_sweep, input bit rst_now);
    logic [6:0] cur;
    @(posedge clk);
    #1;
    cnt_len += int'(clk_length_ctr);
    cnt_sw  += int'(clk_sweep);
    cnt_env += int'(clk_vol_env);
    if (rst_now || (rst_on_sweep && clk_sweep)) begin
      cur = pack_out();
      checks++;
      if (q.size() == 0 || cur !== q[0]) begin
        errors++;
        $display("FAIL pre_rst got %b required %b", cur, (q.size() == 0) ? 7'bx : q[0]);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (pack_out() !== 7'b0) begin
        errors++;
        $display("FAIL async_rst got %b required %b", pack_out(), 7'b0);
      end
      if (clk_sweep === 1'b0 && cur[5] === 1'b1) did_rst = 1;
      q.delete();
      q.push_back('0);
      q.push_back('0);
      n_ev = 0; pre_c = 0; prev_div = 0;
    end else begin
      reset       = 1'b1;
      apu_enable  = en;
      use_ext_div = ext;
      div_bit     = db;
      model_cycle(en, ext, db);
    end
  endtask

  always @(negedge clk) begin
    if (running) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow got empty queue required one entry at t=%0t", $time);
      end else begin
        logic [6:0] exp_v;
        exp_v = q.pop_front();
        if (pack_out() !== exp_v) begin
          errors++;
          $display("FAIL scoreboard t=%0t got lh,len,sw,env,step=%b required %b", $time, pack_out(), exp_v);
        end
      end
    end
  end

  initial begin
    bit en, ext, db;
    int dis_left;
    repeat (2) @(posedge clk);
    #1;
    q.push_back('0);
    reset = 1'b1;
    model_cycle(0, 0, 0);
    running = 1;

    // Internal mode, 8 events in 32 cycles.
    cnt_len = 0; cnt_sw = 0; cnt_env = 0;
    for (int i = 0; i < 33; i++) tick(1, 0, 0, 0, 0);
    chk("int_len_count", cnt_len, 4);
    chk("int_sweep_count", cnt_sw, 2);
    chk("int_env_count", cnt_env, 1);

    // External mode, div_bit period 10 -> 16 falling edges.
    cnt_len = 0; cnt_sw = 0; cnt_env = 0;
    for (int j = 0; j < 165; j++) tick(1, 1, ((j / 5) % 2) == 0, 0, 0);
    chk("ext_len_count", cnt_len, 8);
    chk("ext_sweep_count", cnt_sw, 4);
    chk("ext_env_count", cnt_env, 2);

    // Reset landing on a sweep strobe, bounded.
    for (int k = 0; k < 64 && !did_rst; k++) tick(1, 0, 0, 1, 0);
    chk("rst_on_sweep_seen", int'(did_rst), 1);
    for (int k = 0; k < 40; k++) tick(1, 0, 0, 0, 0);

    // Randomized run: disables, mode switches, DIV activity, occasional resets.
    en = 1; ext = 0; db = 0; dis_left = 0;
    for (int i = 0; i < 2500; i++) begin
      if (dis_left > 0) begin
        dis_left--;
        en = 0;
      end else if ($urandom_range(0, 59) == 0) begin
        dis_left = $urandom_range(0, 2);
        en = 0;
      end else begin
        en = 1;
      end
      if ($urandom_range(0, 49) == 0) ext = !ext;
      if ($urandom_range(0, 2) == 0) db = !db;
      tick(en, ext, db, $urandom_range(0, 7) == 0, $urandom_range(0, 399) == 0);
    end

    @(negedge clk);
    #1;
    running = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
